lag_correlator_core: RTL
========================

// Module: lag_correlator_core
// PURPOSE
//  Parametrised successor to the single-lag pulse correlator. Counts coincidences of every input
//  pair (l<d) over 2*MAX_DELAY+1 discrete sample lags, plus per-input pulse counts, over a window of
//  INTEGRATION_SAMPLES sample strobes. At window end, all counts are snapshotted and streamed out one
//  word at a time over a valid/ready port, toward the UART word transmitter.
// PARAMETERS
//  NUM_INPUTS          8     number of pulse inputs (>=2)
//  RESOLUTION          8     counter/output word width, bits; counters saturate
//  MAX_DELAY           4     max |lag| in samples; DELAY_LINES = 2*MAX_DELAY+1
//  INTEGRATION_SAMPLES 1000  sample strobes per integration window (>=2)
//  derived: NUM_CORRELATORS = NUM_INPUTS*(NUM_INPUTS-1)/2; TOTAL_WORDS = NUM_CORRELATORS*DELAY_LINES+NUM_INPUTS
// PORTS
//  clk          in   1                 single system clock, all logic on posedge
//  reset_n      in   1                 asynchronous, active-low reset
//  pulse_in     in   NUM_INPUTS        pulse levels, synchronous to clk
//  sample_en    in   1                 one-cycle sample strobe (sample clock pulse)
//  enable       in   1                 1 = acquire; 0 = freeze history/counters/window count
//  out_data     out  RESOLUTION        current readout word
//  out_valid    out  1                 out_data valid
//  out_ready    in   1                 consumer accepts word when out_valid&out_ready
//  out_last     out  1                 high with the final word (index TOTAL_WORDS-1)
//  window_done  out  1                 one-cycle pulse, cycle after each window end
//  overrun      out  1                 sticky: a snapshot was dropped because readout was busy
// BEHAVIOUR
//  Reset: history, counters, snapshot, window count, word index = 0; FSM=IDLE; all outputs 0.
//  Acquisition event = posedge with sample_en&enable. No event when enable=0.
//  Tap vector per input i: v_i[0]=pulse_in[i] (live), v_i[j]=history_i[j-1], j=1..2*MAX_DELAY.
//   History shifts one place on each event.
//  Lag k in -MAX_DELAY..+MAX_DELAY, c=MAX_DELAY: the pair (l,d) lag-k counter increments on an event
//   if v_l[c] & v_d[c+k] (l at time u coincides with d at time u-k). Negative k = d later than l.
//  Auto counter i increments on an event if pulse_in[i]. All counters saturate at 2^RESOLUTION-1.
//  History is not cleared at window boundaries, only by reset.
//  Window: sample counter counts events 0..INTEGRATION_SAMPLES-1. The event with count
//   INTEGRATION_SAMPLES-1 is the window end. Its increments are included in the snapshot
//   (snapshot = next-state values). Live counters and sample counter clear to 0 on that edge.
//   window_done pulses on the next cycle.
//  FSM IDLE->READOUT on window end: snapshot loaded, idx=0, out_valid=1 from the next cycle.
//  READOUT: out_data=snapshot[idx]; advance idx on valid&ready. out_data, out_valid and out_last
//   stay stable while out_valid&!out_ready.
//   After the transfer with idx=TOTAL_WORDS-1 -> IDLE, out_valid=0 the next cycle.
//  Word order: pairs in (l,d) order (0,1),(0,2)..(N-2,N-1); within a pair, lag -MAX_DELAY..+MAX_DELAY;
//   then autos 0..N-1.
//  Window end while READOUT: snapshot not overwritten, overrun<=1, live counters still clear.
//   Exception: if the same cycle is the last-word transfer, the new snapshot is loaded,
//   idx=0, FSM stays READOUT, and overrun is not set.
//  enable=0 does not stall readout. reset_n low mid-readout immediately drops out_valid.
//   overrun clears only on reset.
// TESTING
//  1 N=2,MAX_DELAY=1,INT=4: ch0=1 at event 1 only, ch1=1 at event 2 only, out_ready=1
//    -> 5 words [1,0,0,1,1], out_last on word 5, window_done once.
//  2 RESOLUTION=4, both inputs held high for 20 events, INT=32 -> lag0 and autos read 15 (saturated).
//  3 Pseudo-random out_ready during readout -> words never change while stalled, exactly TOTAL_WORDS
//    transfers, matching a reference model.
//  4 out_ready=0 across two window ends -> overrun=1, first snapshot then streams unchanged.
//  5 enable=0 for 10 strobes mid-window -> counts and window length unaffected by those strobes.
//  6 Assert reset_n=0 mid-readout -> out_valid=0 asynchronously; after release a full new window reads
//    correctly with history starting at 0.

Source files
------------

// File: rtl/lag_correlator_core.sv
// Multi-input, multi-lag pulse coincidence correlator with windowed integration
// and a valid/ready word stream carrying the snapshot of each window.

module lag_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt_nxt
);
    logic [W-1:0] cnt;

    // Holds at all-ones instead of wrapping.
    assign cnt_nxt = (inc && cnt != '1) ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else          cnt <= clr ? '0 : cnt_nxt;
    end
endmodule

module lag_correlator_core #(
    parameter int NUM_INPUTS          = 8,
    parameter int RESOLUTION          = 8,
    parameter int MAX_DELAY           = 4,
    parameter int INTEGRATION_SAMPLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_INPUTS-1:0] pulse_in,
    input  logic                  sample_en,
    input  logic                  enable,
    output logic [RESOLUTION-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  window_done,
    output logic                  overrun
);
    localparam int DELAY_LINES     = 2 * MAX_DELAY + 1;
    localparam int HIST_DEPTH      = 2 * MAX_DELAY;
    localparam int NUM_CORRELATORS = NUM_INPUTS * (NUM_INPUTS - 1) / 2;
    localparam int TOTAL_WORDS     = NUM_CORRELATORS * DELAY_LINES + NUM_INPUTS;
    localparam int IDX_W           = $clog2(TOTAL_WORDS);
    localparam int SC_W            = $clog2(INTEGRATION_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_WORDS - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(INTEGRATION_SAMPLES - 1);

    typedef enum logic {IDLE, READOUT} state_t;
    state_t state_q, state_d;

    logic [NUM_INPUTS-1:0][HIST_DEPTH-1:0]           hist;
    logic [NUM_INPUTS-1:0][DELAY_LINES-1:0]          tap;
    logic [TOTAL_WORDS-1:0]                          hit;
    logic [TOTAL_WORDS-1:0][RESOLUTION-1:0]          cnt_nxt;
    logic [TOTAL_WORDS-1:0][RESOLUTION-1:0]          snap;
    logic [SC_W-1:0]                                 samp_cnt;
    logic [IDX_W-1:0]                                idx;
    logic ev, win_end, xfer, last_xfer, load, ovr_set;

    assign ev        = sample_en & enable;
    assign win_end   = ev && (samp_cnt == SC_LAST);
    assign out_valid = (state_q == READOUT);
    assign xfer      = out_valid & out_ready;
    assign last_xfer = xfer && (idx == LAST_IDX);
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign out_data  = out_valid ? snap[idx] : '0;

    // Tap 0 is the live input, tap j is the sample j events ago.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_tap
        assign tap[i] = {hist[i], pulse_in[i]};
        assign hit[NUM_CORRELATORS*DELAY_LINES + i] = pulse_in[i];
    end

    // Pair (l,d) lag k compares l at the centre tap with d at tap c+k; word j = k+MAX_DELAY.
    for (genvar l = 0; l < NUM_INPUTS; l++) begin : g_l
        for (genvar d = l + 1; d < NUM_INPUTS; d++) begin : g_d
            localparam int P = l * NUM_INPUTS - l * (l + 1) / 2 + (d - l - 1);
            for (genvar j = 0; j < DELAY_LINES; j++) begin : g_lag
                assign hit[P*DELAY_LINES + j] = tap[l][MAX_DELAY] & tap[d][j];
            end
        end
    end

    for (genvar w = 0; w < TOTAL_WORDS; w++) begin : g_cnt
        lag_sat_counter #(.W(RESOLUTION)) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (ev & hit[w]),
            .clr     (win_end),
            .cnt_nxt (cnt_nxt[w])
        );
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_end) begin
                    state_d = READOUT;
                    load    = 1'b1;
                end
            end
            READOUT: begin
                // A window ending on the final transfer chains straight into the next readout.
                if (last_xfer) begin
                    if (win_end) load    = 1'b1;
                    else         state_d = IDLE;
                end else if (win_end) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hist        <= '0;
            samp_cnt    <= '0;
            snap        <= '0;
            idx         <= '0;
            window_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            window_done <= win_end;
            if (ovr_set) overrun <= 1'b1;
            if (load) snap <= cnt_nxt;
            if (load || last_xfer) idx <= '0;
            else if (xfer)         idx <= idx + 1'b1;
            if (ev) begin
                for (int i = 0; i < NUM_INPUTS; i++)
                    hist[i] <= {hist[i][HIST_DEPTH-2:0], pulse_in[i]};
                samp_cnt <= win_end ? '0 : samp_cnt + 1'b1;
            end
        end
    end
endmodule
